// File: rtl/gshare_bpd_if.sv
// Fetch-side lookup, prediction and backend update bundle for the gshare predictor.
interface gshare_bpd_if #(
  parameter int GHR_WIDTH   = 8,
  parameter int FETCH_WIDTH = 2
);
  logic                   lookup_valid;
  logic [31:0]            lookup_pc;
  logic                   stall;
  logic                   flush;
  logic                   ready;
  logic                   pred_valid;
  logic [31:0]            pred_pc;
  logic [FETCH_WIDTH-1:0] pred_taken;
  logic [GHR_WIDTH-1:0]   pred_ghr;
  logic                   upd_valid;
  logic [31:0]            upd_pc;
  logic [GHR_WIDTH-1:0]   upd_ghr;
  logic                   upd_taken;

  modport master (
    output lookup_valid, lookup_pc, stall, flush,
    output upd_valid, upd_pc, upd_ghr, upd_taken,
    input  ready, pred_valid, pred_pc, pred_taken, pred_ghr
  );

  modport slave (
    input  lookup_valid, lookup_pc, stall, flush,
    input  upd_valid, upd_pc, upd_ghr, upd_taken,
    output ready, pred_valid, pred_pc, pred_taken, pred_ghr
  );
endinterface

// File: rtl/gshare_bpd.sv
// Gshare direction predictor: PHT of 2-bit counters indexed by PC ^ GHR,
// two-stage lookup pipeline (IF1 -> IF3), single training port, init sweep after reset.
module gshare_bpd #(
  parameter int         PHT_DEPTH   = 1024,
  parameter int         GHR_WIDTH   = 8,
  parameter int         FETCH_WIDTH = 2,
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input  logic           clk,
  input  logic           rst,
  gshare_bpd_if.slave    bus
);
  localparam int IDX_W = $clog2(PHT_DEPTH);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHT_DEPTH - 1);

  logic [0:0]           state;
  logic [IDX_W-1:0]     init_ptr;
  logic [GHR_WIDTH-1:0] ghr;
  logic [1:0]           pht [PHT_DEPTH];

  logic                   s1_valid;
  logic [31:0]            s1_pc;
  logic [GHR_WIDTH-1:0]   s1_ghr;
  logic [IDX_W-1:0]       s1_idx [FETCH_WIDTH];
  logic                   s2_valid;
  logic [31:0]            s2_pc;
  logic [GHR_WIDTH-1:0]   s2_ghr;
  logic [FETCH_WIDTH-1:0] s2_taken;

  logic [IDX_W-1:0] look_idx [FETCH_WIDTH];
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_cur;
  logic [1:0]       upd_next;

  function automatic logic [IDX_W-1:0] pht_idx(input logic [31:0] pc,
                                               input logic [GHR_WIDTH-1:0] h);
    return pc[IDX_W+1:2] ^ IDX_W'(h);
  endfunction

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      look_idx[k] = pht_idx(bus.lookup_pc + 32'(4 * k), ghr);
    end
  end

  // Saturating counter step for the trained entry; read is combinational.
  always_comb begin
    upd_idx  = pht_idx(bus.upd_pc, bus.upd_ghr);
    upd_cur  = pht[upd_idx];
    upd_next = upd_cur;
    if (bus.upd_taken) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
    end
  end

  // Init sweep and training share the single write port; they never overlap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) pht[init_ptr] <= CNT_INIT;
      else if (bus.upd_valid) pht[upd_idx] <= upd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_ptr <= '0;
      ghr      <= '0;
      s1_valid <= 1'b0;
      s1_pc    <= '0;
      s1_ghr   <= '0;
      for (int k = 0; k < FETCH_WIDTH; k++) s1_idx[k] <= '0;
      s2_valid <= 1'b0;
      s2_pc    <= '0;
      s2_ghr   <= '0;
      s2_taken <= '0;
    end else if (state == S_INIT) begin
      init_ptr <= init_ptr + 1'b1;
      if (init_ptr == LAST_IDX) state <= S_RUN;
    end else begin
      if (bus.upd_valid) ghr <= {ghr[GHR_WIDTH-2:0], bus.upd_taken};
      // Stage-2 reads the PHT before this edge's update lands, so it sees the old value.
      if (bus.flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else if (!bus.stall) begin
        s1_valid <= bus.lookup_valid;
        s1_pc    <= bus.lookup_pc;
        s1_ghr   <= ghr;
        s1_idx   <= look_idx;
        s2_valid <= s1_valid;
        s2_pc    <= s1_pc;
        s2_ghr   <= s1_ghr;
        for (int k = 0; k < FETCH_WIDTH; k++) s2_taken[k] <= pht[s1_idx[k]][1];
      end
    end
  end

  assign bus.ready      = (state == S_RUN);
  assign bus.pred_valid = s2_valid;
  assign bus.pred_pc    = s2_pc;
  assign bus.pred_taken = s2_taken;
  assign bus.pred_ghr   = s2_ghr;
endmodule
